display_sequencer: RTL

Parametrised display-mode controller for the bike computer. It cycles through NUM_MODES display modes on mode-button edges, with an optional auto-scroll. It drives one-hot mode indicators that blink on overspeed, and runs a start/valid handshake with the binary-to-ASCII converter. Converter results are latched into a 6-character display register. It replaces the fixed four-mode controller and sits between the measurement datapath and the LCD driver.

---
 rtl/display_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/display_sequencer.sv
// display_sequencer: display-mode controller for the bike computer.
// Steps through NUM_MODES display modes on button edges or auto-scroll,
// blinks the mode annunciators on overspeed, and runs a start/valid
// handshake with the binary-to-ASCII converter.
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   mode               debounced mode button (level)
//   auto_en            auto-scroll enable
//   half_sec_pulse     2 Hz one-cycle strobe (blink timing)
//   sec_pulse          1 Hz one-cycle strobe (scroll, colon, refresh)
//   speed              current speed, compared against SPEED_LIMIT
//   conv_valid/data    converter result strobe and six ASCII bytes
//   mode_sel           one-hot current mode, sent to the converter
//   indicator          LCD mode annunciators
//   conv_start         one-cycle converter request
//   disp_data          latched display characters
//   point, col         decimal point and colon
//   timeout_err        sticky converter-timeout flag
module display_sequencer #(
    parameter int                   NUM_MODES        = 4,
    parameter int                   SPEED_WIDTH      = 12,
    parameter int                   SPEED_LIMIT      = 65,
    parameter logic [NUM_MODES-1:0] POINT_MASK       = 4'b0011,
    parameter logic [NUM_MODES-1:0] COL_MASK         = 4'b0100,
    parameter int                   AUTO_SCROLL_SECS = 5,
    parameter int                   TIMEOUT_CYCLES   = 1023
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mode,
    input  logic                   auto_en,
    input  logic                   half_sec_pulse,
    input  logic                   sec_pulse,
    input  logic [SPEED_WIDTH-1:0] speed,
    input  logic                   conv_valid,
    input  logic [47:0]            conv_data,
    output logic [NUM_MODES-1:0]   mode_sel,
    output logic [NUM_MODES-1:0]   indicator,
    output logic                   conv_start,
    output logic [47:0]            disp_data,
    output logic                   point,
    output logic                   col,
    output logic                   timeout_err
);

    localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int SW = (AUTO_SCROLL_SECS > 1) ?
                        $clog2(AUTO_SCROLL_SECS + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [MW-1:0] LAST_IDX  = MW'(NUM_MODES - 1);
    localparam logic [SW-1:0] SCROLL_TC = SW'((AUTO_SCROLL_SECS > 0) ?
                                              AUTO_SCROLL_SECS - 1 : 0);
    localparam logic [TW-1:0] WAIT_TC   = TW'((TIMEOUT_CYCLES > 0) ?
                                              TIMEOUT_CYCLES - 1 : 0);
    localparam logic [SPEED_WIDTH-1:0] LIMIT = SPEED_WIDTH'(SPEED_LIMIT);
    localparam bit AUTO_ON = (AUTO_SCROLL_SECS != 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } conv_state_e;

    logic [MW-1:0]        idx_q, idx_d;
    logic                 mode_r_q, mode_r_d;
    logic [SW-1:0]        scroll_q, scroll_d;
    logic                 blink_q, blink_d;
    logic                 col_q, col_d;
    logic                 chg_q, chg_d;
    logic                 pend_q, pend_d;
    conv_state_e          state_q, state_d;
    logic [TW-1:0]        wcnt_q, wcnt_d;
    logic [NUM_MODES-1:0] mode_sel_q, mode_sel_d;
    logic [NUM_MODES-1:0] indicator_q, indicator_d;
    logic                 point_q, point_d;
    logic                 conv_start_q, conv_start_d;
    logic [47:0]          disp_q, disp_d;
    logic                 tout_q, tout_d;

    logic btn_edge;
    logic auto_act;
    logic scroll_tc;
    logic advance;
    logic overspeed;
    logic trigger;

    // Mode stepping, scroll counter, blink and annunciator outputs
    always_comb begin
        btn_edge  = mode & ~mode_r_q;
        auto_act  = AUTO_ON && auto_en;
        scroll_tc = auto_act && sec_pulse && (scroll_q == SCROLL_TC);
        // a button edge coinciding with terminal count is one step
        advance   = btn_edge | scroll_tc;
        overspeed = speed > LIMIT;

        mode_r_d = mode;
        chg_d    = advance;

        idx_d = idx_q;
        if (advance) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        scroll_d = scroll_q;
        if (!auto_act || btn_edge || scroll_tc) begin
            scroll_d = '0;
        end else if (sec_pulse) begin
            scroll_d = scroll_q + 1'b1;
        end

        blink_d = blink_q ^ half_sec_pulse;

        mode_sel_d  = NUM_MODES'(1) << idx_d;
        // the active mode stays lit; the others flash on overspeed
        indicator_d = mode_sel_d |
                      ((overspeed && blink_d) ? ~mode_sel_d : '0);
        point_d     = POINT_MASK[idx_d];

        col_d = col_q;
        if (advance || !COL_MASK[idx_q]) begin
            col_d = 1'b0;
        end else if (sec_pulse) begin
            col_d = ~col_q;
        end
    end

    // Converter handshake with a single-entry request queue
    always_comb begin
        trigger      = sec_pulse | chg_q;
        state_d      = state_q;
        pend_d       = pend_q;
        wcnt_d       = wcnt_q;
        disp_d       = disp_q;
        tout_d       = tout_q;
        conv_start_d = (state_q == REQ);

        unique case (state_q)
            IDLE: begin
                if (pend_q || trigger) begin
                    state_d = REQ;
                    pend_d  = 1'b0;
                end
            end
            REQ: begin
                state_d = WAIT;
                wcnt_d  = '0;
                if (trigger) begin
                    pend_d = 1'b1;
                end
            end
            WAIT: begin
                if (trigger) begin
                    pend_d = 1'b1;
                end
                if (conv_valid) begin
                    disp_d  = conv_data;
                    state_d = IDLE;
                end else if (wcnt_q == WAIT_TC) begin
                    tout_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q        <= '0;
            mode_r_q     <= 1'b0;
            scroll_q     <= '0;
            blink_q      <= 1'b0;
            col_q        <= 1'b0;
            chg_q        <= 1'b0;
            pend_q       <= 1'b0;
            state_q      <= IDLE;
            wcnt_q       <= '0;
            mode_sel_q   <= NUM_MODES'(1);
            indicator_q  <= NUM_MODES'(1);
            point_q      <= POINT_MASK[0];
            conv_start_q <= 1'b0;
            disp_q       <= '0;
            tout_q       <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            mode_r_q     <= mode_r_d;
            scroll_q     <= scroll_d;
            blink_q      <= blink_d;
            col_q        <= col_d;
            chg_q        <= chg_d;
            pend_q       <= pend_d;
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            mode_sel_q   <= mode_sel_d;
            indicator_q  <= indicator_d;
            point_q      <= point_d;
            conv_start_q <= conv_start_d;
            disp_q       <= disp_d;
            tout_q       <= tout_d;
        end
    end

    assign mode_sel    = mode_sel_q;
    assign indicator   = indicator_q;
    assign point       = point_q;
    assign col         = col_q;
    assign conv_start  = conv_start_q;
    assign disp_data   = disp_q;
    assign timeout_err = tout_q;

endmodule
